// File: rtl/shift_pipe_stream_pkg.sv
// rtl/shift_pipe_stream_pkg.sv - shared types and sizing helper for the pipelined shifter
//
// Contents:
//   shift_dir_t  - shift direction: SH_LEFT (<<) or SH_RIGHT (logical >>)
//   stage_count  - number of pipeline stages (= shift-amount width) for a data width
package shift_pkg;

    typedef enum logic {
        SH_LEFT  = 1'b0,
        SH_RIGHT = 1'b1
    } shift_dir_t;

    // One stage per shift-amount bit; the extra top bit covers every
    // amount >= width, which flushes the operand to zero.
    function automatic int stage_count(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_pipe_stream_if.sv
// rtl/shift_pipe_stream_if.sv - operand/result handshake bundle for the pipelined shifter
//
// Signals:
//   in_valid/in_ready    operand handshake (in_ready driven by the shifter)
//   in_data, shift, dir  operand, shift amount, direction
//   out_valid/out_ready  result handshake (out_ready driven by the consumer)
//   out_data             shifted result
// Modports:
//   master - the side that issues operands and consumes results
//   slave  - the shifter
interface shift_pipe_stream_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = stage_count(WIDTH)
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   shift;
    shift_dir_t       dir;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, shift, dir, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, shift, dir, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/shift_pipe_stream_stage.sv
// rtl/shift_pipe_stream_stage.sv - one pipeline slice of the shifter: conditional 2^K shift plus register
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   adv                              this slice loads its upstream value this cycle
//   prev_valid/data/shift/dir        upstream slice contents (or the operand port for slice 0)
//   valid/data/shift/dir             registered slice contents
module shift_pipe_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = stage_count(WIDTH),
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SHW-1:0]   prev_shift,
    input  shift_dir_t       prev_dir,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   shift,
    output shift_dir_t       dir
);

    localparam int AMT = 1 << K;

    logic [WIDTH-1:0] moved;
    logic [WIDTH-1:0] shifted;

    // The top slice moves by the full width, which empties the word in
    // either direction; spelling that out avoids an out-of-range shift.
    if (AMT >= WIDTH) begin : g_flush
        assign moved = '0;
    end else begin : g_move
        assign moved = (prev_dir == SH_RIGHT) ? (prev_data >> AMT) : (prev_data << AMT);
    end

    assign shifted = prev_shift[K] ? moved : prev_data;

    // Data fields load whenever the slice advances, valid or not, so an
    // empty slice never carries X forward after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            shift <= '0;
            dir   <= SH_LEFT;
        end else if (adv) begin
            valid <= prev_valid;
            data  <= shifted;
            shift <= prev_shift;
            dir   <= prev_dir;
        end
    end

endmodule

// File: rtl/shift_pipe_stream.sv
// rtl/shift_pipe_stream.sv - pipelined flow-controlled logical shifter, one shift bit per stage
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   shift_pipe_stream_if.slave: operand in (in_valid/in_ready/in_data/shift/dir),
//         result out (out_valid/out_ready/out_data)
module shift_pipe_stream
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = stage_count(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    shift_pipe_stream_if.slave  bus
);

    logic [SHW-1:0]   st_valid;
    logic [SHW-1:0]   adv;
    logic [WIDTH-1:0] st_data  [SHW];
    logic [SHW-1:0]   st_shift [SHW];
    shift_dir_t       st_dir   [SHW];

    // A slice may load when it or any slice downstream of it is empty, or
    // when the consumer takes the result. Walking from the tail with an
    // accumulator lets bubbles collapse past a stalled output.
    always_comb begin : ready_chain
        logic acc;
        acc = bus.out_ready;
        adv = '0;
        for (int k = SHW - 1; k >= 0; k--) begin
            acc    = acc | ~st_valid[k];
            adv[k] = acc;
        end
    end

    assign bus.in_ready = adv[0] & ~rst;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        logic             pv;
        logic [WIDTH-1:0] pd;
        logic [SHW-1:0]   ps;
        shift_dir_t       pdir;

        if (k == 0) begin : g_head
            assign pv   = bus.in_valid;
            assign pd   = bus.in_data;
            assign ps   = bus.shift;
            assign pdir = bus.dir;
        end else begin : g_body
            assign pv   = st_valid[k-1];
            assign pd   = st_data[k-1];
            assign ps   = st_shift[k-1];
            assign pdir = st_dir[k-1];
        end

        shift_pipe_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .K     (k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .adv        (adv[k]),
            .prev_valid (pv),
            .prev_data  (pd),
            .prev_shift (ps),
            .prev_dir   (pdir),
            .valid      (st_valid[k]),
            .data       (st_data[k]),
            .shift      (st_shift[k]),
            .dir        (st_dir[k])
        );
    end

    assign bus.out_valid = st_valid[SHW-1];
    assign bus.out_data  = st_data[SHW-1];

endmodule
